alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Command front-end that sits directly upstream of the 16-bit ALU datapath and also consumes its latched result.
- Accepts one ALU command at a time over a valid/ready handshake and reads operands from a local register file.
- Drives the ALU operand, opcode and latch-strobe inputs, then writes the ALU's latched result back to the destination register.
- Sequential, non-pipelined: one command in flight at a time.

Parameters:
- DATA_W, 16, operand/result width; must match the ALU.
- NUM_REGS, 8, register file depth.
- REG_AW, 3, register address width; must equal log2(NUM_REGS).

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  6  ALU opcode, passed unchanged to alu_op
- cmd_src_a  in  REG_AW  register address for operand A
- cmd_src_b  in  REG_AW  register address for operand B
- cmd_use_imm  in  1  1 = operand B taken from cmd_imm instead of the register file
- cmd_imm  in  DATA_W  immediate value for operand B
- cmd_dst  in  REG_AW  writeback register address
- cmd_set_flags  in  1  1 = update the ALU flags for this command
- alu_oprnd_a  out  DATA_W  to ALU Oprnd_A
- alu_oprnd_b  out  DATA_W  to ALU Oprnd_B
- alu_op  out  6  to ALU ALU_OP
- alu_latch_result  out  1  to ALU Latch_Result
- alu_latch_flags  out  1  to ALU Latch_Flags
- alu_result  in  DATA_W  from ALU Lachd_Result
- ext_wr_en  in  1  external register-file write request
- ext_wr_addr  in  REG_AW  external write address
- ext_wr_data  in  DATA_W  external write data
- ext_wr_ready  out  1  external write accepted this cycle
- rd_addr  in  REG_AW  debug read address
- rd_data  out  DATA_W  combinational read of rf[rd_addr]
- done_valid  out  1  one-cycle pulse: writeback performed
- done_dst  out  REG_AW  register written; valid with done_valid

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE.
  - All register-file entries and all registered outputs go to 0.
  - During reset: cmd_ready=0 and ext_wr_ready=0.
  - Reset asserted mid-command aborts the command: no writeback, no done_valid.
- State machine: IDLE -> ISSUE -> EXEC -> WB -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready:
    - Capture alu_oprnd_a = rf[cmd_src_a].
    - Capture alu_oprnd_b = cmd_use_imm ? cmd_imm : rf[cmd_src_b].
    - Capture alu_op = cmd_op, plus dst and set_flags.
    - Go to ISSUE.
- ISSUE:
  - Operands are stable.
  - Go to EXEC.
- EXEC:
  - alu_latch_result=1 for exactly this cycle.
  - alu_latch_flags = captured set_flags for exactly this cycle.
  - Go to WB.
- WB:
  - alu_result is valid.
  - At the clock edge ending WB, rf[dst] <= alu_result.
  - done_valid=1 and done_dst=dst for this one cycle.
  - Go to IDLE.
- Latency: handshake edge to rf update = 3 clocks. Maximum throughput is 1 command per 4 clocks.
- cmd_ready is 0 in ISSUE, EXEC and WB. Commands presented then are not accepted; cmd_valid may stay high.
- Operands and opcode hold their captured values from ISSUE until the next accept. They are not cleared in IDLE.
- Strobes (alu_latch_result, alu_latch_flags, done_valid) are 0 in every state except the one named above.
- External write:
  - ext_wr_ready = (state != WB).
  - When ext_wr_en & ext_wr_ready, rf[ext_wr_addr] <= ext_wr_data.
  - An external write during WB is not performed; the writer must hold the request.
- Same-cycle external write and command accept: the command samples the OLD register value (no forwarding). The write still completes.
- src_a == src_b, or dst equal to a source: legal, with no special handling.
- Widths: no arithmetic in this block. All values pass through unmodified at DATA_W.

Optional Feature:
- Macro: ALU_OP_SEQ_ILLEGAL_OP_EN.
- Legal opcodes: 0x00-0x07 and 0x10-0x1F.
- When defined:
  - Add output err_illegal_op (1 bit, reset 0).
  - A command with any other opcode is still accepted, but goes IDLE -> IDLE.
  - err_illegal_op pulses for 1 cycle on the cycle after the accept.
  - No ALU strobes, no writeback, no done_valid.
- When not defined:
  - Port absent.
  - Every opcode runs through the full sequence.

Test Plan:
- Reset then idle: rf all 0, cmd_ready=1, all strobes 0, rd_data=0 for every address.
- ext write r1=0x0005, r2=0x0003; cmd op=0x00 src_a=1 src_b=2 dst=3 set_flags=1 -> alu_latch_result and alu_latch_flags high 2 cycles after accept; rf[3]=0x0008 after 3 clocks; done_valid pulse with done_dst=3.
- cmd op=0x05 src_a=2, use_imm=1, imm=0x0003, dst=4, set_flags=0 -> alu_latch_flags stays 0; rf[4]=0x0000; done_dst=4.
- cmd_valid held high continuously with two commands -> second accepted exactly 4 clocks after the first; cmd_ready low for 3 cycles between accepts.
- ext_wr_en during WB to addr 5 -> ext_wr_ready=0, rf[5] unchanged; write lands the next cycle.
- reset_n low during EXEC -> rf cleared, no done_valid; with ALU_OP_SEQ_ILLEGAL_OP_EN, op=0x09 -> err_illegal_op pulse, rf unchanged, cmd_ready back to 1 the next cycle.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Single-issue command front-end for the 16-bit ALU: reads operands from a local register file,
// strobes the ALU, writes the latched result back. Optional: ALU_OP_SEQ_ILLEGAL_OP_EN.
module alu_op_sequencer #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned REG_AW   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [5:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_src_a,
    input  logic [REG_AW-1:0] cmd_src_b,
    input  logic              cmd_use_imm,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic [REG_AW-1:0] cmd_dst,
    input  logic              cmd_set_flags,
    output logic [DATA_W-1:0] alu_oprnd_a,
    output logic [DATA_W-1:0] alu_oprnd_b,
    output logic [5:0]        alu_op,
    output logic              alu_latch_result,
    output logic              alu_latch_flags,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              ext_wr_en,
    input  logic [REG_AW-1:0] ext_wr_addr,
    input  logic [DATA_W-1:0] ext_wr_data,
    output logic              ext_wr_ready,
    input  logic [REG_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
`ifdef ALU_OP_SEQ_ILLEGAL_OP_EN
    output logic              err_illegal_op,
`endif
    output logic              done_valid,
    output logic [REG_AW-1:0] done_dst
);

    typedef enum logic [1:0] {StIdle, StIssue, StExec, StWb} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] oprnd_a_q, oprnd_a_d;
    logic [DATA_W-1:0] oprnd_b_q, oprnd_b_d;
    logic [5:0]        op_q, op_d;
    logic [REG_AW-1:0] dst_q, dst_d;
    logic              set_flags_q, set_flags_d;
    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic              accept;
    logic              wb_en;
    logic              ext_we;
    logic              op_illegal;

`ifdef ALU_OP_SEQ_ILLEGAL_OP_EN
    logic err_q, err_d;

    // Legal opcode space: 0x00-0x07 and 0x10-0x1F.
    always_comb begin
        op_illegal = !((cmd_op[5:3] == 3'b000) || (cmd_op[5:4] == 2'b01));
        err_d      = accept & op_illegal;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_illegal_op = err_q;
`else
    assign op_illegal = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        oprnd_a_d        = oprnd_a_q;
        oprnd_b_d        = oprnd_b_q;
        op_d             = op_q;
        dst_d            = dst_q;
        set_flags_d      = set_flags_q;
        cmd_ready        = 1'b0;
        accept           = 1'b0;
        alu_latch_result = 1'b0;
        alu_latch_flags  = 1'b0;
        done_valid       = 1'b0;
        wb_en            = 1'b0;
        // Both readies are forced low while reset is held.
        ext_wr_ready     = reset_n;
        unique case (state_q)
            StIdle: begin
                cmd_ready = reset_n;
                accept    = cmd_valid & reset_n;
                if (accept) begin
                    oprnd_a_d   = rf_q[cmd_src_a];
                    oprnd_b_d   = cmd_use_imm ? cmd_imm : rf_q[cmd_src_b];
                    op_d        = cmd_op;
                    dst_d       = cmd_dst;
                    set_flags_d = cmd_set_flags;
                    state_d     = op_illegal ? StIdle : StIssue;
                end
            end
            StIssue: state_d = StExec;
            StExec: begin
                alu_latch_result = 1'b1;
                alu_latch_flags  = set_flags_q;
                state_d          = StWb;
            end
            StWb: begin
                ext_wr_ready = 1'b0;
                done_valid   = 1'b1;
                wb_en        = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            oprnd_a_q   <= '0;
            oprnd_b_q   <= '0;
            op_q        <= '0;
            dst_q       <= '0;
            set_flags_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            oprnd_a_q   <= oprnd_a_d;
            oprnd_b_q   <= oprnd_b_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            set_flags_q <= set_flags_d;
        end
    end

    assign ext_we = ext_wr_en & ext_wr_ready;

    // External writes are blocked in WB, so the two write ports never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (ext_we) begin
                rf_q[ext_wr_addr] <= ext_wr_data;
            end
            if (wb_en) begin
                rf_q[dst_q] <= alu_result;
            end
        end
    end

    assign rd_data     = rf_q[rd_addr];
    assign alu_oprnd_a = oprnd_a_q;
    assign alu_oprnd_b = oprnd_b_q;
    assign alu_op      = op_q;
    assign done_dst    = dst_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small ALU stub that latches on alu_latch_result.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_op = '0;
    logic [2:0]  cmd_src_a = '0;
    logic [2:0]  cmd_src_b = '0;
    logic        cmd_use_imm = 1'b0;
    logic [15:0] cmd_imm = '0;
    logic [2:0]  cmd_dst = '0;
    logic        cmd_set_flags = 1'b0;
    logic [15:0] alu_oprnd_a;
    logic [15:0] alu_oprnd_b;
    logic [5:0]  alu_op;
    logic        alu_latch_result;
    logic        alu_latch_flags;
    logic [15:0] alu_result = '0;
    logic        ext_wr_en = 1'b0;
    logic [2:0]  ext_wr_addr = '0;
    logic [15:0] ext_wr_data = '0;
    logic        ext_wr_ready;
    logic [2:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        done_valid;
    logic [2:0]  done_dst;
`ifdef ALU_OP_SEQ_ILLEGAL_OP_EN
    logic        err_illegal_op;
`endif

    int n_cmp = 0;
    int n_err = 0;

    alu_op_sequencer #(.DATA_W(16), .NUM_REGS(8), .REG_AW(3)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_src_a        (cmd_src_a),
        .cmd_src_b        (cmd_src_b),
        .cmd_use_imm      (cmd_use_imm),
        .cmd_imm          (cmd_imm),
        .cmd_dst          (cmd_dst),
        .cmd_set_flags    (cmd_set_flags),
        .alu_oprnd_a      (alu_oprnd_a),
        .alu_oprnd_b      (alu_oprnd_b),
        .alu_op           (alu_op),
        .alu_latch_result (alu_latch_result),
        .alu_latch_flags  (alu_latch_flags),
        .alu_result       (alu_result),
        .ext_wr_en        (ext_wr_en),
        .ext_wr_addr      (ext_wr_addr),
        .ext_wr_data      (ext_wr_data),
        .ext_wr_ready     (ext_wr_ready),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
`ifdef ALU_OP_SEQ_ILLEGAL_OP_EN
        .err_illegal_op   (err_illegal_op),
`endif
        .done_valid       (done_valid),
        .done_dst         (done_dst)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_model(input logic [5:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        case (op)
            6'h00:   return a + b;
            6'h01:   return a - b;
            6'h02:   return a & b;
            6'h03:   return a | b;
            6'h04:   return a ^ b;
            6'h05:   return a - b;
            default: return a;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_latch_result) alu_result <= alu_model(alu_op, alu_oprnd_a, alu_oprnd_b);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input logic [2:0] addr, input logic [15:0] exp, input string name);
        rd_addr = addr;
        #1;
        check(name, {16'h0, rd_data}, {16'h0, exp});
    endtask

    task automatic ext_write(input logic [2:0] addr, input logic [15:0] data);
        ext_wr_en   = 1'b1;
        ext_wr_addr = addr;
        ext_wr_data = data;
        tick();
        ext_wr_en   = 1'b0;
    endtask

    task automatic set_cmd(input logic [5:0] op, input logic [2:0] sa, input logic [2:0] sb,
                           input logic ui, input logic [15:0] imm, input logic [2:0] dst,
                           input logic fl);
        cmd_op = op; cmd_src_a = sa; cmd_src_b = sb; cmd_use_imm = ui;
        cmd_imm = imm; cmd_dst = dst; cmd_set_flags = fl;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [2:0]  sa;
        logic [2:0]  sb;
        logic        ui;
        logic [15:0] imm;
        logic [2:0]  dst;
        logic        fl;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic [15:0] exp_res;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lows;
        int waited;
        // Expected values assume r1=5, r2=3 preloaded and earlier vectors applied in order.
        vecs[0] = '{6'h00, 3'd1, 3'd2, 1'b0, 16'h0000, 3'd3, 1'b1, 16'h0005, 16'h0003, 16'h0008};
        vecs[1] = '{6'h05, 3'd2, 3'd0, 1'b1, 16'h0003, 3'd4, 1'b0, 16'h0003, 16'h0003, 16'h0000};
        vecs[2] = '{6'h01, 3'd3, 3'd1, 1'b0, 16'h0000, 3'd6, 1'b1, 16'h0008, 16'h0005, 16'h0003};
        vecs[3] = '{6'h02, 3'd1, 3'd0, 1'b1, 16'h00FF, 3'd7, 1'b0, 16'h0005, 16'h00FF, 16'h0005};
        vecs[4] = '{6'h04, 3'd3, 3'd3, 1'b0, 16'h0000, 3'd3, 1'b1, 16'h0008, 16'h0008, 16'h0000};
        vecs[5] = '{6'h1F, 3'd6, 3'd0, 1'b0, 16'h0000, 3'd2, 1'b1, 16'h0003, 16'h0000, 16'h0003};

        #12;
        check("reset_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("reset_ext_wr_ready", {31'h0, ext_wr_ready}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("idle_strobes", {29'h0, alu_latch_result, alu_latch_flags, done_valid}, 32'h0);
        check("idle_oprnd_a", {16'h0, alu_oprnd_a}, 32'h0);
        for (int i = 0; i < 8; i++) check_rf(3'(i), 16'h0000, "reset_rf");

        ext_write(3'd1, 16'h0005);
        ext_write(3'd2, 16'h0003);

        for (int v = 0; v < 6; v++) begin
            waited = 0;
            while (!cmd_ready && waited < 20) begin
                tick();
                waited++;
            end
            check("vec_ready_before_accept", {31'h0, cmd_ready}, 32'h1);
            set_cmd(vecs[v].op, vecs[v].sa, vecs[v].sb, vecs[v].ui, vecs[v].imm, vecs[v].dst,
                    vecs[v].fl);
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            check("vec_issue_ready", {31'h0, cmd_ready}, 32'h0);
            check("vec_issue_latch", {31'h0, alu_latch_result}, 32'h0);
            check("vec_oprnd_a", {16'h0, alu_oprnd_a}, {16'h0, vecs[v].exp_a});
            check("vec_oprnd_b", {16'h0, alu_oprnd_b}, {16'h0, vecs[v].exp_b});
            check("vec_alu_op", {26'h0, alu_op}, {26'h0, vecs[v].op});
            tick();
            check("vec_exec_latch_result", {31'h0, alu_latch_result}, 32'h1);
            check("vec_exec_latch_flags", {31'h0, alu_latch_flags}, {31'h0, vecs[v].fl});
            check("vec_exec_done", {31'h0, done_valid}, 32'h0);
            tick();
            check("vec_wb_done", {31'h0, done_valid}, 32'h1);
            check("vec_wb_done_dst", {29'h0, done_dst}, {29'h0, vecs[v].dst});
            check("vec_wb_latch", {30'h0, alu_latch_result, alu_latch_flags}, 32'h0);
            check("vec_wb_ext_ready", {31'h0, ext_wr_ready}, 32'h0);
            tick();
            check("vec_idle_done", {31'h0, done_valid}, 32'h0);
            check("vec_idle_oprnd_hold", {16'h0, alu_oprnd_a}, {16'h0, vecs[v].exp_a});
            check_rf(vecs[v].dst, vecs[v].exp_res, "vec_rf_result");
        end

        // Back-to-back with cmd_valid held: r5 = r1+r1 = 10, then r6 = r5+r1 = 15.
        set_cmd(6'h00, 3'd1, 3'd1, 1'b0, 16'h0, 3'd5, 1'b0);
        cmd_valid = 1'b1;
        tick();
        set_cmd(6'h00, 3'd5, 3'd1, 1'b0, 16'h0, 3'd6, 1'b0);
        lows = 0;
        for (int k = 0; k < 10 && !cmd_ready; k++) begin
            lows++;
            tick();
        end
        check("b2b_ready_low_cycles", lows, 32'd3);
        tick();
        cmd_valid = 1'b0;
        check("b2b_second_accepted", {31'h0, cmd_ready}, 32'h0);
        check("b2b_second_oprnd_a", {16'h0, alu_oprnd_a}, 32'h000A);
        check("b2b_second_oprnd_b", {16'h0, alu_oprnd_b}, 32'h0005);
        tick(); tick(); tick();
        check_rf(3'd5, 16'h000A, "b2b_r5");
        check_rf(3'd6, 16'h000F, "b2b_r6");

        // External write held across WB lands one cycle later.
        set_cmd(6'h00, 3'd1, 3'd1, 1'b0, 16'h0, 3'd7, 1'b0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        ext_wr_en = 1'b1; ext_wr_addr = 3'd5; ext_wr_data = 16'hBEEF;
        #1;
        check("wb_ext_wr_ready", {31'h0, ext_wr_ready}, 32'h0);
        tick();
        check("post_wb_ext_wr_ready", {31'h0, ext_wr_ready}, 32'h1);
        check_rf(3'd5, 16'h000A, "wb_ext_blocked_r5");
        check_rf(3'd7, 16'h000A, "wb_result_r7");
        tick();
        ext_wr_en = 1'b0;
        check_rf(3'd5, 16'hBEEF, "ext_landed_r5");

        // Same-cycle external write and accept: command sees the old r1.
        set_cmd(6'h00, 3'd1, 3'd1, 1'b0, 16'h0, 3'd4, 1'b0);
        cmd_valid = 1'b1;
        ext_wr_en = 1'b1; ext_wr_addr = 3'd1; ext_wr_data = 16'h0100;
        tick();
        cmd_valid = 1'b0;
        ext_wr_en = 1'b0;
        check("same_cycle_old_a", {16'h0, alu_oprnd_a}, 32'h0005);
        check_rf(3'd1, 16'h0100, "same_cycle_ext_r1");
        tick(); tick(); tick();
        check_rf(3'd4, 16'h000A, "same_cycle_r4");

        // Reset during EXEC aborts the command.
        set_cmd(6'h00, 3'd1, 3'd1, 1'b0, 16'h0, 3'd3, 1'b0);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("pre_reset_exec", {31'h0, alu_latch_result}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("midrst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("midrst_ext_ready", {31'h0, ext_wr_ready}, 32'h0);
        check("midrst_latch", {31'h0, alu_latch_result}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("midrst_no_done", {31'h0, done_valid}, 32'h0);
        end
        reset_n = 1'b1;
        tick();
        check("post_rst_done", {31'h0, done_valid}, 32'h0);
        check("post_rst_ready", {31'h0, cmd_ready}, 32'h1);
        for (int i = 0; i < 8; i++) check_rf(3'(i), 16'h0000, "post_rst_rf");

`ifdef ALU_OP_SEQ_ILLEGAL_OP_EN
        ext_write(3'd1, 16'h1234);
        set_cmd(6'h09, 3'd1, 3'd1, 1'b0, 16'h0, 3'd2, 1'b1);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("illegal_err_pulse", {31'h0, err_illegal_op}, 32'h1);
        check("illegal_ready", {31'h0, cmd_ready}, 32'h1);
        check("illegal_no_latch", {31'h0, alu_latch_result}, 32'h0);
        tick();
        check("illegal_err_clear", {31'h0, err_illegal_op}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            check("illegal_no_strobe",
                  {29'h0, alu_latch_result, alu_latch_flags, done_valid}, 32'h0);
            tick();
        end
        check_rf(3'd2, 16'h0000, "illegal_rf_unchanged");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
